// File: rtl/spike_encoder_element.sv
// Purpose: rate-coded spike generator; integrate-and-fire with subtractive reset turns a latched activation into T spikes/no-spikes.
// Latency: spike/spike_valid are registered, one cycle after each step_en edge; done coincides with the final spike_valid (or one cycle after accept when T=0).
// Backpressure: start is only accepted while ready_o=1 (IDLE); step_en_i paces the run and stalls it (all state held) while low.
//
// Ports:
//   clk_i, rst_i              : clock and synchronous active-high reset
//   start_i                   : request to encode one value (accepted when ready_o=1)
//   value_i, threshold_i      : signed activation and firing threshold, sampled on accept
//   num_timesteps_i           : run length T, sampled on accept
//   step_en_i                 : advance one timestep while running
//   ready_o                   : block is idle and will accept start_i
//   spike_o, spike_valid_o    : spike for the timestep just processed, qualified by spike_valid_o
//   spike_count_o             : running count of spikes in the current/last run
//   done_o                    : one-cycle end-of-run pulse

module spike_encoder_element #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMESTEP_WIDTH = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic signed [DATA_WIDTH-1:0]     value_i,
    input  logic signed [DATA_WIDTH-1:0]     threshold_i,
    input  logic        [TIMESTEP_WIDTH-1:0] num_timesteps_i,
    input  logic                             step_en_i,
    output logic                             ready_o,
    output logic                             spike_o,
    output logic                             spike_valid_o,
    output logic        [TIMESTEP_WIDTH-1:0] spike_count_o,
    output logic                             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    // value and threshold are kept as non-negative magnitudes: the value is
    // ReLU-clamped at latch, and a threshold <= 0 is folded into fire_en_q,
    // so the datapath below can be purely unsigned.
    logic [DATA_WIDTH-1:0]     value_q, value_d;
    logic [DATA_WIDTH-1:0]     thr_q, thr_d;
    logic                      fire_en_q, fire_en_d;
    logic [DATA_WIDTH-1:0]     acc_q, acc_d;
    logic [TIMESTEP_WIDTH-1:0] num_ts_q, num_ts_d;
    logic [TIMESTEP_WIDTH-1:0] t_q, t_d;
    logic [TIMESTEP_WIDTH-1:0] count_q, count_d;
    logic                      spike_q, spike_d;
    logic                      spike_valid_q, spike_valid_d;

    // Integrate datapath, one bit wider than the operands. While firing is
    // enabled acc stays below threshold and value is at most 2^(W-1)-1, so
    // the sum always fits in DATA_WIDTH+1 bits and the residue after
    // subtracting the threshold fits back into DATA_WIDTH bits.
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   excess;
    logic [DATA_WIDTH-1:0] thr_m1;
    logic [DATA_WIDTH-1:0] acc_fire;
    logic                  fire;
    logic                  last_step;

    assign sum    = {1'b0, acc_q} + {1'b0, value_q};
    assign excess = sum - {1'b0, thr_q};
    assign thr_m1 = thr_q - DATA_WIDTH'(1);
    assign fire   = fire_en_q && (sum >= {1'b0, thr_q});

    // Residue is capped at threshold-1 so a huge value cannot build up
    // charge without bound; such a value simply fires on every step.
    assign acc_fire = (excess > {1'b0, thr_m1}) ? thr_m1 : excess[DATA_WIDTH-1:0];

    // num_ts_q is never 0 in RUN (T=0 goes straight to DONE), so T-1 is safe.
    assign last_step = (t_q == (num_ts_q - TIMESTEP_WIDTH'(1)));

    always_comb begin
        state_d       = state_q;
        value_d       = value_q;
        thr_d         = thr_q;
        fire_en_d     = fire_en_q;
        acc_d         = acc_q;
        num_ts_d      = num_ts_q;
        t_d           = t_q;
        count_d       = count_q;
        spike_d       = spike_q;
        spike_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    value_d   = value_i[DATA_WIDTH-1] ? '0 : value_i;
                    thr_d     = threshold_i;
                    fire_en_d = !threshold_i[DATA_WIDTH-1] && (|threshold_i);
                    num_ts_d  = num_timesteps_i;
                    acc_d     = '0;
                    t_d       = '0;
                    count_d   = '0;
                    state_d   = (num_timesteps_i == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                // start_i is deliberately not looked at here.
                if (step_en_i) begin
                    spike_valid_d = 1'b1;
                    t_d           = t_q + TIMESTEP_WIDTH'(1);
                    if (fire) begin
                        spike_d = 1'b1;
                        count_d = count_q + TIMESTEP_WIDTH'(1);
                        acc_d   = acc_fire;
                    end else begin
                        spike_d = 1'b0;
                        // With firing disabled this may wrap; acc is then
                        // never compared, so the wrap is harmless.
                        acc_d   = sum[DATA_WIDTH-1:0];
                    end
                    if (last_step) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // Single-cycle state; start and step_en are ignored.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            value_q       <= '0;
            thr_q         <= '0;
            fire_en_q     <= 1'b0;
            acc_q         <= '0;
            num_ts_q      <= '0;
            t_q           <= '0;
            count_q       <= '0;
            spike_q       <= 1'b0;
            spike_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            value_q       <= value_d;
            thr_q         <= thr_d;
            fire_en_q     <= fire_en_d;
            acc_q         <= acc_d;
            num_ts_q      <= num_ts_d;
            t_q           <= t_d;
            count_q       <= count_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
        end
    end

    // done is decoded from the one-cycle DONE state, which lines it up with
    // the final spike_valid pulse produced by the edge that entered DONE.
    always_comb begin
        ready_o       = (state_q == ST_IDLE);
        done_o        = (state_q == ST_DONE);
        spike_o       = spike_q;
        spike_valid_o = spike_valid_q;
        spike_count_o = count_q;
    end

endmodule

// File: tb/tb_spike_encoder_element.sv
module tb_spike_encoder_element;

    localparam int DW = 16;
    localparam int TW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic signed [DW-1:0] value;
    logic signed [DW-1:0] threshold;
    logic [TW-1:0]        num_ts;
    logic                 step_en;
    logic                 ready;
    logic                 spike;
    logic                 spike_valid;
    logic [TW-1:0]        spike_count;
    logic                 done;

    int errors = 0;
    int checks = 0;

    // Expected spike per timestep for the run about to be checked.
    bit exp_q[$];

    always #5 clk = ~clk;

    spike_encoder_element #(
        .DATA_WIDTH    (DW),
        .TIMESTEP_WIDTH(TW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .value_i        (value),
        .threshold_i    (threshold),
        .num_timesteps_i(num_ts),
        .step_en_i      (step_en),
        .ready_o        (ready),
        .spike_o        (spike),
        .spike_valid_o  (spike_valid),
        .spike_count_o  (spike_count),
        .done_o         (done)
    );

    // Reference: integrate-and-fire on plain integers.
    function automatic void build_model(input int v, input int thr, input int n);
        int acc;
        int s;
        exp_q.delete();
        acc = 0;
        if (v < 0) v = 0;
        for (int i = 0; i < n; i++) begin
            s = acc + v;
            if (thr > 0 && s >= thr) begin
                exp_q.push_back(1'b1);
                acc = s - thr;
                if (acc > thr - 1) acc = thr - 1;
            end else begin
                exp_q.push_back(1'b0);
                acc = s;
            end
        end
    endfunction

    // One complete run. mode: 0 = step every cycle, 1 = one on / two off,
    // 2 = random. hold_start keeps start high (with different operands)
    // through RUN and DONE.
    task automatic run_case(input string name, input int v, input int thr, input int n,
                            input int mode, input bit hold_start);
        int steps;
        int cnt;
        int cyc;
        int bound;
        bit prev_step;
        bit exp_valid;
        bit exp_done;
        bit fin;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_start got=%b exp=1", name, ready);
        end
        start     = 1'b1;
        value     = v[DW-1:0];
        threshold = thr[DW-1:0];
        num_ts    = n[TW-1:0];
        step_en   = (mode == 0);
        steps = 0; cnt = 0; cyc = 0; prev_step = 1'b0; fin = 1'b0;
        bound = 20 * n + 40;
        while (!fin && cyc < bound) begin
            @(negedge clk);
            if (hold_start) begin
                value     = DW'(v + 50);
                threshold = 16'sd1;
                num_ts    = '0;
            end else begin
                start = 1'b0;
            end
            exp_valid = prev_step;
            checks++;
            if (spike_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s spike_valid cyc=%0d got=%b exp=%b", name, cyc, spike_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (spike !== exp_q[steps]) begin
                    errors++;
                    $display("FAIL %s spike step=%0d got=%b exp=%b", name, steps, spike, exp_q[steps]);
                end
                cnt += int'(exp_q[steps]);
                steps++;
            end
            exp_done = (n == 0) ? (cyc == 0) : (exp_valid && steps == n);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", name, cyc, done, exp_done);
            end
            checks++;
            if (spike_count !== cnt[TW-1:0]) begin
                errors++;
                $display("FAIL %s spike_count cyc=%0d got=%0d exp=%0d", name, cyc, spike_count, cnt);
            end
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_busy cyc=%0d got=%b exp=0", name, cyc, ready);
            end
            if (exp_done) begin
                fin = 1'b1;
            end else begin
                case (mode)
                    0:       step_en = 1'b1;
                    1:       step_en = (cyc % 3 == 2);
                    default: step_en = 1'($urandom_range(0, 1));
                endcase
                prev_step = step_en;
            end
            cyc++;
        end
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout waiting for done got_steps=%0d exp_steps=%0d", name, steps, n);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || spike_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done ready/done/valid got=%b%b%b exp=100", name, ready, done, spike_valid);
        end
        checks++;
        if (spike_count !== cnt[TW-1:0]) begin
            errors++;
            $display("FAIL %s held_count got=%0d exp=%0d", name, spike_count, cnt);
        end
        start   = 1'b0;
        step_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || spike !== 1'b0 || spike_valid !== 1'b0 || done !== 1'b0 || spike_count !== '0) begin
            errors++;
            $display("FAIL reset outputs ready/spike/valid/done/count got=%b%b%b%b/%0d exp=1000/0",
                     ready, spike, spike_valid, done, spike_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        run_case("basic", 3, 4, 8, 0, 1'b0);
        checks++;
        if (spike_count !== 8'd6) begin
            errors++;
            $display("FAIL basic final_count got=%0d exp=6", spike_count);
        end
    endtask

    task automatic test_saturate;
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_case("saturate", 100, 10, 5, 0, 1'b0);
        // Leftover charge from the previous run would fire here if acc were
        // not cleared on accept.
        exp_q = '{1'b0, 1'b0, 1'b0};
        run_case("acc_rezero", 0, 5, 3, 0, 1'b0);
    endtask

    task automatic test_disabled;
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
        run_case("relu_clamp", -5, 4, 4, 0, 1'b0);
        run_case("thr_zero", 7, 0, 4, 0, 1'b0);
        run_case("thr_neg", 7, -2, 4, 0, 1'b0);
    endtask

    task automatic test_zero_len;
        exp_q.delete();
        run_case("t_zero", 9, 1, 0, 0, 1'b0);
    endtask

    task automatic test_start_ignored;
        build_model(3, 4, 4);
        run_case("start_held", 3, 4, 4, 0, 1'b1);
    endtask

    task automatic test_gapped;
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        run_case("gapped", 3, 4, 8, 1, 1'b0);
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        start = 1'b1; value = 16'sd3; threshold = 16'sd4; num_ts = 8'd8; step_en = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        step_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (spike_count !== 8'd2 || spike_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrun before_reset count/valid got=%0d/%b exp=2/1", spike_count, spike_valid);
        end
        rst     = 1'b1;
        step_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || spike_count !== '0 || done !== 1'b0 || spike_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun after_reset ready/count/done/valid got=%b/%0d/%b/%b exp=1/0/0/0",
                     ready, spike_count, done, spike_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun no_done got done=%b ready=%b exp done=0 ready=1", done, ready);
        end
        exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        run_case("after_reset", 3, 4, 8, 0, 1'b0);
    endtask

    task automatic test_random;
        int v;
        int thr;
        int n;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                v   = int'($urandom_range(0, 32767));
                thr = int'($urandom_range(1, 32767));
            end else begin
                v   = int'($urandom_range(0, 600)) - 100;
                thr = int'($urandom_range(0, 300)) - 20;
            end
            n = int'($urandom_range(0, 12));
            build_model(v, thr, n);
            run_case("random", v, thr, n, ($urandom_range(0, 1) == 0) ? 0 : 2,
                     1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        step_en   = 1'b0;
        value     = '0;
        threshold = '0;
        num_ts    = '0;
        test_reset();
        test_basic();
        test_saturate();
        test_disabled();
        test_zero_len();
        test_start_ignored();
        test_gapped();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
